// File: rtl/serializer_piso_stream.sv
// Parallel-in/serial-out converter: accepts WIDTH-bit words over valid/ready and emits
// one bit per clock, with a one-word holding register for gapless back-to-back words.
module serializer_piso_stream #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MSB_FIRST  = 1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             data_out,
  output logic             out_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [WIDTH-1:0] r_hold, w_hold_nxt;
  logic             r_hold_full, w_hold_full_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_data_out, w_data_out_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_last_bit, w_last_bit_nxt;
  logic             w_accept;

  // The bit currently on the line always sits at the "front" end of r_shift.
  function automatic logic first_bit(input logic [WIDTH-1:0] word);
    return (MSB_FIRST != 0) ? word[WIDTH-1] : word[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] word);
    return (MSB_FIRST != 0) ? {word[WIDTH-2:0], 1'b0} : {1'b0, word[WIDTH-1:1]};
  endfunction

  assign din_ready = !r_hold_full;
  assign w_accept  = din_valid && din_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_cnt_nxt       = r_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_shift_nxt = din;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == LAST_CNT) begin
          // End of word: a held word wins over a fresh accept; din_ready is low then anyway.
          if (r_hold_full) begin
            w_shift_nxt     = r_hold;
            w_hold_full_nxt = 1'b0;
            w_cnt_nxt       = '0;
          end else if (w_accept) begin
            w_shift_nxt = din;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_shift_nxt = advance(r_shift);
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          if (w_accept) begin
            w_hold_nxt      = din;
            w_hold_full_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_out_valid_nxt = (w_state_nxt == ST_SHIFT);
    w_last_bit_nxt  = w_out_valid_nxt && (w_cnt_nxt == LAST_CNT);
    w_data_out_nxt  = w_out_valid_nxt ? first_bit(w_shift_nxt) : IDLE_LEVEL;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
      r_data_out  <= IDLE_LEVEL;
      r_out_valid <= 1'b0;
      r_last_bit  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_cnt       <= w_cnt_nxt;
      r_data_out  <= w_data_out_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_last_bit  <= w_last_bit_nxt;
    end
  end

  assign data_out  = r_data_out;
  assign out_valid = r_out_valid;
  assign last_bit  = r_last_bit;
  assign busy      = (r_state == ST_SHIFT) || r_hold_full;

endmodule

// File: tb/tb_serializer_piso_stream.sv
// Directed bench for serializer_piso_stream: one MSB-first and one LSB-first instance,
// with per-instance scoreboards of expected serial bits filled at accept time.
module tb_serializer_piso_stream;

  localparam int W = 8;

  typedef struct packed {
    logic d;
    logic last;
  } exp_t;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] din_m = '0, din_l = '0;
  logic         valid_m = 1'b0, valid_l = 1'b0;
  logic         ready_m, dout_m, ov_m, last_m, busy_m;
  logic         ready_l, dout_l, ov_l, last_l, busy_l;

  int   total = 0;
  int   bad   = 0;
  exp_t q_m[$];
  exp_t q_l[$];
  exp_t e_m, e_l;
  int   run_m = 0, max_run_m = 0;

  always #5 clk = ~clk;

  serializer_piso_stream #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .reset(reset), .din(din_m), .din_valid(valid_m), .din_ready(ready_m),
    .data_out(dout_m), .out_valid(ov_m), .last_bit(last_m), .busy(busy_m)
  );

  serializer_piso_stream #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din_l), .din_valid(valid_l), .din_ready(ready_l),
    .data_out(dout_l), .out_valid(ov_l), .last_bit(last_l), .busy(busy_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w, input bit msb);
    for (int i = 0; i < W; i++) begin
      exp_t e;
      e.d    = msb ? w[W-1-i] : w[i];
      e.last = (i == W - 1);
      if (msb) q_m.push_back(e);
      else     q_l.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting posedge.
  task automatic send(input bit msb, input logic [W-1:0] w);
    int n = 0;
    if (msb) begin din_m = w; valid_m = 1'b1; end
    else     begin din_l = w; valid_l = 1'b1; end
    while (!(msb ? ready_m : ready_l) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", n < 50, 1);
    push_word(w, msb);
    @(negedge clk);
    if (msb) valid_m = 1'b0;
    else     valid_l = 1'b0;
  endtask

  task automatic wait_idle(input bit msb);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((msb ? (ov_m || busy_m) : (ov_l || busy_l)) && n < 100);
    check("drain_in_time", n < 100, 1);
  endtask

  task automatic wait_last_m();
    int n = 0;
    while (!last_m && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("last_bit_seen", last_m, 1);
  endtask

  // Scoreboard monitors sample on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (reset && ov_m) begin
      run_m++;
      if (run_m > max_run_m) max_run_m = run_m;
      check("msb_sb_has_entry", q_m.size() != 0, 1);
      if (q_m.size() != 0) begin
        e_m = q_m.pop_front();
        check("msb_data", dout_m, e_m.d);
        check("msb_last", last_m, e_m.last);
      end
    end else begin
      run_m = 0;
    end
  end

  always @(negedge clk) begin
    if (reset && ov_l) begin
      check("lsb_sb_has_entry", q_l.size() != 0, 1);
      if (q_l.size() != 0) begin
        e_l = q_l.pop_front();
        check("lsb_data", dout_l, e_l.d);
        check("lsb_last", last_l, e_l.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_outputs_msb", {dout_m, ov_m, last_m, busy_m, ready_m}, 5'b00001);
    check("rst_outputs_lsb", {dout_l, ov_l, last_l, busy_l, ready_l}, 5'b00001);
    reset = 1'b1;

    // Idle level: line stays low and invalid with no input
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_level", {dout_m, ov_m, dout_l, ov_l}, 4'b0000);
    end

    // Single word, latency 1, exactly 8 valid cycles
    max_run_m = 0;
    send(1'b1, 8'b1110_0000);
    check("single_first_bit", {ov_m, dout_m}, 2'b11);
    wait_idle(1'b1);
    check("single_len", max_run_m, 8);
    check("single_sb_empty", q_m.size(), 0);
    check("single_idle_line", {dout_m, ov_m}, 2'b00);

    // Back-to-back through the holding register
    max_run_m = 0;
    send(1'b1, 8'hFF);
    send(1'b1, 8'h0F);
    check("b2b_ready_low", ready_m, 0);
    check("b2b_busy", busy_m, 1);
    wait_last_m();
    check("b2b_ready_low_at_last", ready_m, 0);
    @(negedge clk);
    check("b2b_ready_rises", ready_m, 1);
    wait_idle(1'b1);
    check("b2b_gapless_len", max_run_m, 16);
    check("b2b_sb_empty", q_m.size(), 0);

    // Same-cycle reload on the last_bit cycle, hold empty
    max_run_m = 0;
    send(1'b1, 8'h81);
    wait_last_m();
    send(1'b1, 8'hA5);
    check("reload_first_bit", {ov_m, dout_m, last_m}, 3'b110);
    check("reload_hold_empty", ready_m, 1);
    wait_idle(1'b1);
    check("reload_gapless_len", max_run_m, 16);

    // LSB-first ordering
    send(1'b0, 8'b0000_0111);
    check("lsb_bit0", dout_l, 1);
    @(negedge clk);
    check("lsb_bit1", dout_l, 1);
    @(negedge clk);
    check("lsb_bit2", dout_l, 1);
    @(negedge clk);
    check("lsb_bit3", dout_l, 0);
    wait_idle(1'b0);
    check("lsb_sb_empty", q_l.size(), 0);

    // Asynchronous reset mid-word with a word held
    send(1'b1, 8'hFF);
    send(1'b1, 8'h3C);
    @(negedge clk);
    check("midrst_hold_full", ready_m, 0);
    #2 reset = 1'b0;
    #1;
    check("midrst_async", {dout_m, ov_m, last_m, busy_m, ready_m}, 5'b00001);
    q_m.delete();
    @(negedge clk);
    reset = 1'b1;
    max_run_m = 0;
    repeat (12) @(negedge clk);
    check("midrst_no_residual", max_run_m, 0);
    check("midrst_idle", {dout_m, ov_m, busy_m, ready_m}, 4'b0001);

    check("final_sb_msb_empty", q_m.size(), 0);
    check("final_sb_lsb_empty", q_l.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
